// File: rtl/reg_file_ext.sv
// Byte-writable register file with two combinational read ports and a hardware clear sweep.
// Latency: reads are zero-cycle; writes land at the next posedge, with optional same-cycle forwarding.
// Backpressure: none. While busy is high, writes are dropped and both read ports return zero.
//
// Ports:
//   clk, rst_n    single clock; asynchronous active-low reset that starts a clear sweep
//   clear         requests a clear sweep when in RUN; ignored while a sweep is already running
//   write, be     write enable and per-byte enables (be[i] covers WD[8i+7:8i])
//   WR, WD        write address and write data
//   RR1/RR2       read addresses; RD1/RD2 carry the read data
//   busy          high while the clear sweep is in progress
module reg_file_ext #(
   parameter int DW      = 32,
   parameter int AW      = 5,
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            write,
   input  logic [DW/8-1:0] be,
   input  logic [AW-1:0]   WR,
   input  logic [DW-1:0]   WD,
   input  logic [AW-1:0]   RR1,
   input  logic [AW-1:0]   RR2,
   output logic [DW-1:0]   RD1,
   output logic [DW-1:0]   RD2,
   output logic            busy
);

   localparam int NREG = 1 << AW;
   localparam int NB   = DW / 8;
   localparam bit ZR   = (ZERO_R0 != 0);
   localparam bit BP   = (BYPASS != 0);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [DW-1:0]   mem [NREG];
   logic            wr_en;
   logic [DW-1:0]   wr_merged;

   // Bytes with be set come from the new data; the rest keep the old value.
   function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [NB-1:0] en);
      logic [DW-1:0] r;
      r = old_v;
      for (int i = 0; i < NB; i++) begin
         if (en[i]) begin
            r[8*i +: 8] = new_v[8*i +: 8];
         end
      end
      return r;
   endfunction

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         CLEAR: begin
            // clear is deliberately not sampled here: a running sweep is never restarted.
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == {AW{1'b1}}) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (clear) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   assign busy = (state_q == CLEAR);

   // A write is accepted only in RUN and loses to a simultaneous clear.
   // Register 0 is read-only when hard-wired to zero.
   assign wr_en = (state_q == RUN) && write && !clear && !(ZR && (WR == '0));

   assign wr_merged = byte_merge(mem[WR], WD, be);

   // ---------------- storage ----------------
   // Storage itself carries no reset; its contents become defined once the sweep completes.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem[ptr_q] <= '0;
      end else if (wr_en) begin
         mem[WR] <= wr_merged;
      end
   end

   // ---------------- read ports ----------------
   function automatic logic [DW-1:0] read_port(input logic [AW-1:0] addr,
                                               input logic          is_busy,
                                               input logic          fwd_en,
                                               input logic [AW-1:0] fwd_addr,
                                               input logic [DW-1:0] fwd_data,
                                               input logic [DW-1:0] stored);
      logic [DW-1:0] r;
      r = stored;
      if (is_busy) begin
         r = '0;
      end else if (ZR && (addr == '0)) begin
         r = '0;
      end else if (BP && fwd_en && (addr == fwd_addr)) begin
         r = fwd_data;
      end
      return r;
   endfunction

   always_comb begin
      RD1 = read_port(RR1, busy, wr_en, WR, wr_merged, mem[RR1]);
      RD2 = read_port(RR2, busy, wr_en, WR, wr_merged, mem[RR2]);
   end

endmodule

// File: tb/tb_reg_file_ext.sv
module tb_reg_file_ext;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        write;
   logic [3:0]  be;
   logic [4:0]  WR;
   logic [31:0] WD;
   logic [4:0]  RR1;
   logic [4:0]  RR2;
   logic [31:0] RD1;
   logic [31:0] RD2;
   logic        busy;

   int checks = 0;
   int errors = 0;

   reg_file_ext #(.DW(32), .AW(5), .BYPASS(1), .ZERO_R0(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .write (write),
      .be    (be),
      .WR    (WR),
      .WD    (WD),
      .RR1   (RR1),
      .RR2   (RR2),
      .RD1   (RD1),
      .RD2   (RD2),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wen;
      logic [3:0]  ben;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Caller is positioned before the first sweep posedge. Counts posedges until busy
   // drops (bounded); optionally pulses clear at sweep cycle 'pulse'.
   task automatic wait_sweep(input int exp, input string nm, input int pulse);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      while (!done && n < 100) begin
         clear = (n == pulse);
         @(posedge clk);
         #1;
         n++;
         if (!busy) done = 1'b1;
         else if (n == 5) check({nm, "_rd_busy"}, RD1 | RD2, 32'h0);
         @(negedge clk);
      end
      clear = 1'b0;
      check(nm, n, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{1'b1, 4'hF, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1]  = '{1'b0, 4'hF, 5'd5,  32'h00000000, 5'd5,  5'd3,  32'hDEADBEEF, 32'h00000000};
      vecs[2]  = '{1'b1, 4'h2, 5'd5,  32'h0000AA00, 5'd5,  5'd5,  32'hDEADAAEF, 32'hDEADAAEF};
      vecs[3]  = '{1'b0, 4'h0, 5'd0,  32'h00000000, 5'd5,  5'd0,  32'hDEADAAEF, 32'h00000000};
      vecs[4]  = '{1'b1, 4'hF, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
      vecs[5]  = '{1'b0, 4'h0, 5'd0,  32'h00000000, 5'd0,  5'd5,  32'h00000000, 32'hDEADAAEF};
      vecs[6]  = '{1'b1, 4'h5, 5'd9,  32'h11223344, 5'd9,  5'd5,  32'h00220044, 32'hDEADAAEF};
      vecs[7]  = '{1'b1, 4'h0, 5'd9,  32'hFFFFFFFF, 5'd9,  5'd9,  32'h00220044, 32'h00220044};
      vecs[8]  = '{1'b1, 4'hF, 5'd31, 32'hAABBCCDD, 5'd31, 5'd9,  32'hAABBCCDD, 32'h00220044};
      vecs[9]  = '{1'b1, 4'h8, 5'd31, 32'h11000000, 5'd31, 5'd30, 32'h11BBCCDD, 32'h00000000};
      vecs[10] = '{1'b0, 4'h0, 5'd0,  32'h00000000, 5'd31, 5'd31, 32'h11BBCCDD, 32'h11BBCCDD};

      rst_n = 1'b0; clear = 1'b0; write = 1'b0; be = 4'h0;
      WR = '0; WD = '0; RR1 = 5'd5; RR2 = 5'd17;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd1);
      check("rst_rd1", RD1, 32'h0);
      check("rst_rd2", RD2, 32'h0);

      // First sweep after release
      @(negedge clk);
      rst_n = 1'b1;
      wait_sweep(32, "sweep_len", -1);

      for (int a = 0; a < 32; a += 7) begin
         RR1 = 5'(a);
         RR2 = 5'(31 - a);
         #1;
         check($sformatf("post_sweep_rd1_a%0d", a), RD1, 32'h0);
         check($sformatf("post_sweep_rd2_a%0d", 31 - a), RD2, 32'h0);
      end

      // Table-driven vectors: same-cycle read data, with forwarding
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         write = vecs[i].wen; be = vecs[i].ben; WR = vecs[i].wa; WD = vecs[i].wd;
         RR1 = vecs[i].ra1; RR2 = vecs[i].ra2;
         #1;
         check($sformatf("vec%0d_rd1", i), RD1, vecs[i].e1);
         check($sformatf("vec%0d_rd2", i), RD2, vecs[i].e2);
      end

      // clear and write in the same RUN cycle: clear wins
      @(negedge clk);
      write = 1'b1; clear = 1'b1; be = 4'hF; WR = 5'd7; WD = 32'h12345678;
      RR1 = 5'd7; RR2 = 5'd5;
      #1;
      check("clrwr_no_fwd", RD1, 32'h0);
      check("clrwr_rd2_old", RD2, 32'hDEADAAEF);
      @(posedge clk);
      #1;
      check("clr_busy", {31'd0, busy}, 32'd1);
      check("clr_rd1_zero", RD1, 32'h0);
      @(negedge clk);
      write = 1'b0; clear = 1'b0;
      // A clear pulse during the sweep must not restart it
      wait_sweep(32, "clr_sweep_len", 10);
      RR1 = 5'd5; RR2 = 5'd7;
      #1;
      check("clr_r5", RD1, 32'h0);
      check("clr_r7", RD2, 32'h0);
      RR1 = 5'd31; RR2 = 5'd9;
      #1;
      check("clr_r31", RD1, 32'h0);
      check("clr_r9", RD2, 32'h0);

      // Store a value, then reset mid-RUN
      @(negedge clk);
      write = 1'b1; be = 4'hF; WR = 5'd3; WD = 32'h00000055; RR1 = 5'd3;
      @(negedge clk);
      write = 1'b0;
      #1;
      check("r3_stored", RD1, 32'h00000055);
      rst_n = 1'b0;
      #1;
      check("run_rst_busy", {31'd0, busy}, 32'd1);
      check("run_rst_rd1", RD1, 32'h0);

      // Release, then reset again at sweep cycle 10
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      wait_sweep(32, "mid_rst_sweep_len", -1);
      RR1 = 5'd3; RR2 = 5'd31;
      #1;
      check("final_r3", RD1, 32'h0);
      check("final_r31", RD2, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
